// File: rtl/pdp_rdma_ig_req_gen.sv
// PDP RDMA input-stage read-request generator.
// Walks the source cube surface -> line -> atom chunks and issues one read
// request per chunk of up to MAX_ATOMS atoms on a registered valid/ready port.
module pdp_rdma_ig_req_gen #(
  parameter int ATOM_BYTES = 32,
  parameter int MAX_ATOMS  = 8
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        op_load,
  input  logic [63:0] reg_src_base_addr,
  input  logic [31:0] reg_line_stride,
  input  logic [31:0] reg_surf_stride,
  input  logic [12:0] reg_width,
  input  logic [12:0] reg_height,
  input  logic [7:0]  reg_surf_num,
  output logic        cv_int_rd_req_valid_d0,
  output logic [78:0] cv_int_rd_req_pd_d0,
  input  logic        cv_int_rd_req_ready_d0,
  output logic        req_busy,
  output logic        req_done
);

  localparam int         ATOM_SHIFT = $clog2(ATOM_BYTES);
  localparam logic [13:0] MAX_A     = 14'(MAX_ATOMS);

  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] sh_line_stride, sh_surf_stride;
  logic [12:0] sh_width, sh_height;
  logic [7:0]  sh_surf_num;
  logic [13:0] atom_cnt, atom_cnt_nxt;
  logic [12:0] line_cnt, line_cnt_nxt;
  logic [7:0]  surf_cnt, surf_cnt_nxt;
  logic [63:0] line_base, line_base_nxt;
  logic [63:0] surf_base, surf_base_nxt;
  logic        valid_nxt, done_nxt;
  logic [78:0] pd_nxt;
  logic [63:0] load_base;
  logic [63:0] new_surf_base, new_line_base;
  logic [13:0] chunk, atom_sum;
  logic        line_end, surf_end, last_chunk;
  logic        load_fire, hs;

  // Atoms in the chunk starting at acnt on a line of (width+1) atoms.
  function automatic logic [13:0] chunk_of(input logic [13:0] acnt, input logic [12:0] width);
    logic [13:0] rem;
    rem = {1'b0, width} + 14'd1 - acnt;
    chunk_of = (rem > MAX_A) ? MAX_A : rem;
  endfunction

  // Request payload: {size-1, byte address} for the chunk starting at acnt.
  function automatic logic [78:0] make_pd(input logic [63:0] lbase, input logic [13:0] acnt,
                                          input logic [12:0] width);
    logic [13:0] c;
    logic [63:0] addr;
    c    = chunk_of(acnt, width);
    addr = lbase + ({50'd0, acnt} << ATOM_SHIFT);
    make_pd = {1'b0, c - 14'd1, addr};
  endfunction

  // Position bookkeeping for the request currently on the port.
  always_comb begin
    load_fire     = (state == IDLE) && op_load;
    hs            = cv_int_rd_req_valid_d0 && cv_int_rd_req_ready_d0;
    load_base     = reg_src_base_addr & ~64'h1F;
    chunk         = chunk_of(atom_cnt, sh_width);
    atom_sum      = atom_cnt + chunk;
    line_end      = (atom_sum == ({1'b0, sh_width} + 14'd1));
    surf_end      = line_end && (line_cnt == sh_height);
    last_chunk    = surf_end && (surf_cnt == sh_surf_num);
    new_surf_base = surf_base + {32'd0, sh_surf_stride};
    new_line_base = line_base + {32'd0, sh_line_stride};
  end

  // Next-state, counter advance and next request payload.
  always_comb begin
    state_nxt     = state;
    atom_cnt_nxt  = atom_cnt;
    line_cnt_nxt  = line_cnt;
    surf_cnt_nxt  = surf_cnt;
    line_base_nxt = line_base;
    surf_base_nxt = surf_base;
    valid_nxt     = cv_int_rd_req_valid_d0;
    pd_nxt        = cv_int_rd_req_pd_d0;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (load_fire) begin
          state_nxt     = REQ;
          atom_cnt_nxt  = 14'd0;
          line_cnt_nxt  = 13'd0;
          surf_cnt_nxt  = 8'd0;
          line_base_nxt = load_base;
          surf_base_nxt = load_base;
          valid_nxt     = 1'b1;
          pd_nxt        = make_pd(load_base, 14'd0, reg_width);
        end else begin
          valid_nxt     = 1'b0;
        end
      end
      REQ: begin
        if (!hs) begin
          valid_nxt = cv_int_rd_req_valid_d0;
        end else if (last_chunk) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          done_nxt  = 1'b1;
        end else if (surf_end) begin
          atom_cnt_nxt  = 14'd0;
          line_cnt_nxt  = 13'd0;
          surf_cnt_nxt  = surf_cnt + 8'd1;
          surf_base_nxt = new_surf_base;
          line_base_nxt = new_surf_base;
          pd_nxt        = make_pd(new_surf_base, 14'd0, sh_width);
        end else if (line_end) begin
          atom_cnt_nxt  = 14'd0;
          line_cnt_nxt  = line_cnt + 13'd1;
          line_base_nxt = new_line_base;
          pd_nxt        = make_pd(new_line_base, 14'd0, sh_width);
        end else begin
          atom_cnt_nxt  = atom_sum;
          pd_nxt        = make_pd(line_base, atom_sum, sh_width);
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // State, counters, shadow configuration and registered outputs.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state                  <= IDLE;
      atom_cnt               <= 14'd0;
      line_cnt               <= 13'd0;
      surf_cnt               <= 8'd0;
      line_base              <= 64'd0;
      surf_base              <= 64'd0;
      sh_line_stride         <= 32'd0;
      sh_surf_stride         <= 32'd0;
      sh_width               <= 13'd0;
      sh_height              <= 13'd0;
      sh_surf_num            <= 8'd0;
      cv_int_rd_req_valid_d0 <= 1'b0;
      cv_int_rd_req_pd_d0    <= 79'd0;
      req_busy               <= 1'b0;
      req_done               <= 1'b0;
    end else begin
      state                  <= state_nxt;
      atom_cnt               <= atom_cnt_nxt;
      line_cnt               <= line_cnt_nxt;
      surf_cnt               <= surf_cnt_nxt;
      line_base              <= line_base_nxt;
      surf_base              <= surf_base_nxt;
      cv_int_rd_req_valid_d0 <= valid_nxt;
      cv_int_rd_req_pd_d0    <= pd_nxt;
      req_busy               <= (state_nxt == REQ);
      req_done               <= done_nxt;
      if (load_fire) begin
        sh_line_stride <= reg_line_stride;
        sh_surf_stride <= reg_surf_stride;
        sh_width       <= reg_width;
        sh_height      <= reg_height;
        sh_surf_num    <= reg_surf_num;
      end else begin
        sh_line_stride <= sh_line_stride;
        sh_surf_stride <= sh_surf_stride;
        sh_width       <= sh_width;
        sh_height      <= sh_height;
        sh_surf_num    <= sh_surf_num;
      end
    end
  end

endmodule

// File: doc/pdp_rdma_ig_req_gen.md
Name: pdp_rdma_ig_req_gen

Overview:
- Read-request generator for the PDP RDMA input stage. It walks the configured source cube surface by surface, then line by line, then along each line in 32-byte atoms.
- Emits one DMA read request per chunk of at most MAX_ATOMS atoms on a valid/ready interface.
- Sits directly upstream of the p4 request skid/pipe stage and drives its d0 side: cv_int_rd_req_valid_d0, cv_int_rd_req_pd_d0 and cv_int_rd_req_ready_d0.

Parameters:
- ATOM_BYTES, 32, bytes per atom; address step per atom.
- MAX_ATOMS, 8, max atoms per request (power of two, 1..16).

Ports:
- nvdla_core_clk  in  1  core clock; all logic on rising edge
- nvdla_core_rst  in  1  synchronous, active-high reset
- op_load  in  1  start pulse; accepted only when req_busy=0
- reg_src_base_addr  in  64  cube base byte address; bits [4:0] ignored (treated 0)
- reg_line_stride  in  32  byte distance between lines
- reg_surf_stride  in  32  byte distance between surfaces
- reg_width  in  13  atoms per line minus 1
- reg_height  in  13  lines per surface minus 1
- reg_surf_num  in  8  surfaces minus 1
- cv_int_rd_req_valid_d0  out  1  request valid
- cv_int_rd_req_pd_d0  out  79  [63:0] byte address, [78:64] size in atoms minus 1
- cv_int_rd_req_ready_d0  in  1  downstream ready
- req_busy  out  1  operation in progress
- req_done  out  1  one-cycle pulse after last request handshake

Behaviour:
- Reset, synchronous, active-high: all outputs 0, FSM IDLE, all counters and accumulators 0. Reset mid-operation aborts it with no req_done; the next op_load starts fresh.
- FSM states: IDLE, REQ.
  - IDLE + op_load: capture all reg_* into shadow registers; surf_base=line_base=base; atom_cnt=line_cnt=surf_cnt=0; go to REQ; req_busy=1.
  - First request is valid in the cycle after op_load (latency 1).
- Outputs valid and pd are flops. While valid=1 and ready=0, pd and valid hold stable; no request is dropped or skipped.
- Handshake is valid && ready. Throughput is one request per cycle under continuous ready.
- Request fields:
  - addr = line_base + atom_cnt*ATOM_BYTES
  - rem = shadow_width+1-atom_cnt
  - size = min(MAX_ATOMS, rem)-1
- On handshake:
  - atom_cnt += size+1.
  - If the line is finished: atom_cnt=0 and line_cnt++, line_base += line_stride.
  - If the surface is finished: line_cnt=0, surf_cnt++, surf_base += surf_stride, line_base = new surf_base.
  - If this is the last chunk of the last line of the last surface: valid=0 next cycle, req_done=1 for exactly that cycle, req_busy=0, FSM to IDLE.
- Arithmetic:
  - 64-bit modulo 2^64; address wrap-around is silent.
  - Strides are zero-extended to 64 bits.
  - atom_cnt width 14 so no overflow at width=8191.
- op_load while req_busy=1 is ignored. op_load in the same cycle req_done=1 is accepted (FSM is already IDLE).
- Config inputs may change freely while busy; only the shadow copies are used.
- Request count per line = ceil((reg_width+1)/MAX_ATOMS). Total = that × (reg_height+1) × (reg_surf_num+1).

Test Plan:
- Line split: base=0x1000, width=19, height=0, surf=0, ready=1 → requests (0x1000,size7),(0x1100,7),(0x1200,3) on consecutive cycles starting one cycle after op_load; req_done one cycle after third handshake.
- Multi-line/surface: base=0, width=7, height=2, line_stride=0x400, surf_num=1, surf_stride=0x10000 → six size-7 requests at 0x0,0x400,0x800,0x10000,0x10400,0x10800; then done.
- Backpressure: case 1 with ready held low 5 cycles on the second request, then random ready → pd stable while stalled, identical request sequence, no duplicates or gaps.
- Back-to-back ops: op_load during busy → ignored; op_load in req_done cycle with base=0x2000, width=0 → single request (0x2000,0) next cycle.
- Reset mid-op: rst after 2 handshakes of case 2 → valid=0, busy=0 next cycle, no done; new op_load restarts at base 0.
- Wrap: base=0xFFFF_FFFF_FFFF_FFE0, width=0, height=1, line_stride=0x40 → addresses 0xFFFF_FFFF_FFFF_FFE0 then 0x20.
